alu_pipe_unit: RTL and testbench
================================

ALU_PIPE_UNIT -- requirements
Module: alu_pipe_unit

Interface
REQ-001 Parameter XLEN, default 32, operand and result width; SHALL be a power of two, 8 or more.
REQ-002 Parameter TAG_W, default 6, width of the destination tag carried with each operation.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  an operation is offered.
REQ-006 in_ready  output  1  unit accepts the offered operation this cycle.
REQ-007 in_ctrl  input  4  opcode.
REQ-008 in_a, in_b  input  XLEN  operands.
REQ-009 in_tag  input  TAG_W  destination tag.
REQ-010 flush  input  1  discard all in-flight and held work.
REQ-011 out_valid  output  1  result register holds a valid result.
REQ-012 out_ready  input  1  consumer takes the result this cycle.
REQ-013 out_result  output  XLEN  result.
REQ-014 out_zero  output  1  out_result is all zeros.
REQ-015 out_negative  output  1  out_result[XLEN-1].
REQ-016 out_tag  output  TAG_W  tag of the held result.
REQ-017 busy  output  1  multiply in progress.

Function
REQ-018 Opcodes SHALL be: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 sll, 0110 srl, 0111 sra, 1000 slt signed, 1001 sltu, 1010 mul (low XLEN bits of the product); all others SHALL yield result 0.
REQ-019 Shift amount SHALL be in_b[log2(XLEN)-1:0]; add, sub and mul SHALL wrap modulo 2^XLEN; slt and sltu SHALL yield 1 or 0, zero-extended.
REQ-020 Accept SHALL occur when in_valid and in_ready are both high and flush is low.
REQ-021 in_ready SHALL equal (state==IDLE) and (not out_valid or out_ready) and not flush.
REQ-022 Single-cycle ops (all except 1010) SHALL load result, zero, negative and tag into the output register on the accept edge; out_valid SHALL be high the following cycle.
REQ-023 FSM states SHALL be IDLE and MUL; accepting 1010 SHALL move IDLE to MUL, capturing operands, the tag and iteration count 0.
REQ-024 MUL SHALL perform one shift-add step per cycle for XLEN cycles; on the XLEN-th step edge it SHALL load the output register, set out_valid and return to IDLE; out_valid rises XLEN edges after the accept edge.
REQ-025 busy SHALL be high exactly while state==MUL; in_ready SHALL be low in MUL.
REQ-026 out_valid SHALL clear on an edge with out_valid and out_ready high unless a new result loads on that same edge, in which case it SHALL stay high with the new contents.
REQ-027 Output contents SHALL remain stable while out_valid is high and out_ready is low.
REQ-028 flush SHALL, on the edge where it is high, clear out_valid, abort any multiply to IDLE and block accept; flush SHALL take priority over completion and accept on the same edge.
REQ-029 out_zero and out_negative SHALL be registered with out_result, never recomputed combinationally.

Reset
REQ-030 rst high SHALL immediately force state IDLE, out_valid 0, busy 0, out_result 0, out_zero 0, out_negative 0, out_tag 0 and iteration count 0.
REQ-031 rst asserted mid-multiply SHALL discard that multiply; no result for it SHALL ever appear.
REQ-032 in_ready SHALL be low while rst is high.

Structure
REQ-033 Opcode constants, the FSM state encoding and the default XLEN SHALL reside in a shared package alu_pkg.
REQ-034 The single-cycle function (REQ-018 except mul, and REQ-019) SHALL be a combinational sub-module alu_core parametrised by XLEN; the FSM, multiplier and output register SHALL be in alu_pipe_unit.

Verification
REQ-035 XLEN=32, add 0xFFFFFFFF+1, tag 5, out_ready=1 -> next cycle out_valid=1, result 0, zero=1, tag 5.
REQ-036 sra 0x80000000 by 0x21 -> shift 1, result 0xC0000000, negative=1; sltu 1 vs 0xFFFFFFFF -> 1.
REQ-037 mul 0x10000 x 0x10001, tag 9 -> busy for 32 cycles, in_ready=0 throughout, then result 0x00010000, tag 9.
REQ-038 Back-to-back add/sub with out_ready=0 for 3 cycles -> first result held stable, in_ready=0, second accepted on the edge out_ready returns high, no loss or duplication.
REQ-039 flush at multiply cycle 10 -> busy drops next cycle, no result emitted, next op accepted the following cycle.
REQ-040 rst asserted mid-multiply, deasserted 2 cycles later -> all outputs 0 immediately, no result for the aborted op.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared opcode constants, FSM state encoding and default
//                operand width for the pipelined ALU unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
//  Module      : alu_core
//  Description : Combinational single-cycle ALU datapath. Multiply and all
//                undefined opcodes produce zero here; the multiply result
//                comes from the sequential multiplier in the parent.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [3:0]      ctrl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);

  localparam int SH_W = $clog2(XLEN);

  logic [SH_W-1:0] shamt;

  assign shamt = b[SH_W-1:0];

  // Opcode decode: one arithmetic/logic result per cycle.
  always_comb begin
    result = '0;
    case (ctrl)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLL:  result = a << shamt;
      OP_SRL:  result = a >> shamt;
      OP_SRA:  result = $unsigned($signed(a) >>> shamt);
      OP_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      default: result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_pipe_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe_unit
//  Description : ALU with a registered, backpressured result stage and an
//                iterative shift-add multiplier (one step per cycle, XLEN
//                steps). Flush aborts work and drops any held result.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe_unit
  import alu_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_ctrl,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic             out_zero,
  output logic             out_negative,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int              CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]    mcand_q, mcand_d;
  logic [XLEN-1:0]    mplier_q, mplier_d;
  logic [XLEN-1:0]    acc_q, acc_d;
  logic [TAG_W-1:0]   mtag_q, mtag_d;
  logic               out_valid_q, out_valid_d;
  logic [XLEN-1:0]    out_result_q, out_result_d;
  logic               out_zero_q, out_zero_d;
  logic               out_negative_q, out_negative_d;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;

  logic [XLEN-1:0]    core_result;
  logic [XLEN-1:0]    step_acc;
  logic [XLEN-1:0]    load_res;
  logic [TAG_W-1:0]   load_tag;
  logic               load;
  logic               accept;

  alu_core #(
    .XLEN (XLEN)
  ) u_core (
    .ctrl   (in_ctrl),
    .a      (in_a),
    .b      (in_b),
    .result (core_result)
  );

  // Ready only when idle, the output slot is free or draining, and not flushing or in reset.
  assign in_ready     = (state_q == ST_IDLE) && (!out_valid_q || out_ready) && !flush && !rst;
  assign accept       = in_valid && in_ready;
  assign busy         = (state_q == ST_MUL);
  assign out_valid    = out_valid_q;
  assign out_result   = out_result_q;
  assign out_zero     = out_zero_q;
  assign out_negative = out_negative_q;
  assign out_tag      = out_tag_q;

  // Next-state: flush dominates; otherwise drain, accept, multiply step, and output load.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    mcand_d        = mcand_q;
    mplier_d       = mplier_q;
    acc_d          = acc_q;
    mtag_d         = mtag_q;
    out_valid_d    = out_valid_q;
    out_result_d   = out_result_q;
    out_zero_d     = out_zero_q;
    out_negative_d = out_negative_q;
    out_tag_d      = out_tag_q;
    step_acc       = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    load           = 1'b0;
    load_res       = core_result;
    load_tag       = in_tag;

    if (flush) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (in_ctrl == OP_MUL) begin
              state_d  = ST_MUL;
              cnt_d    = '0;
              mcand_d  = in_a;
              mplier_d = in_b;
              acc_d    = '0;
              mtag_d   = in_tag;
            end else begin
              load = 1'b1;
            end
          end
        end
        ST_MUL: begin
          acc_d    = step_acc;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            load     = 1'b1;
            load_res = step_acc;
            load_tag = mtag_q;
            state_d  = ST_IDLE;
            cnt_d    = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase

      if (load) begin
        out_valid_d    = 1'b1;
        out_result_d   = load_res;
        out_zero_d     = (load_res == '0);
        out_negative_d = load_res[XLEN-1];
        out_tag_d      = load_tag;
      end
    end
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      mcand_q        <= '0;
      mplier_q       <= '0;
      acc_q          <= '0;
      mtag_q         <= '0;
      out_valid_q    <= 1'b0;
      out_result_q   <= '0;
      out_zero_q     <= 1'b0;
      out_negative_q <= 1'b0;
      out_tag_q      <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mcand_q        <= mcand_d;
      mplier_q       <= mplier_d;
      acc_q          <= acc_d;
      mtag_q         <= mtag_d;
      out_valid_q    <= out_valid_d;
      out_result_q   <= out_result_d;
      out_zero_q     <= out_zero_d;
      out_negative_q <= out_negative_d;
      out_tag_q      <= out_tag_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_pipe_unit
//  Description : Self-checking bench for alu_pipe_unit: directed vectors,
//                multi-cycle corner sequences and a random scoreboard run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipe_unit;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_ctrl;
  logic [31:0] in_a, in_b;
  logic [5:0]  in_tag;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_negative;
  logic [5:0]  out_tag;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  alu_pipe_unit #(.XLEN(32), .TAG_W(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_negative(out_negative),
    .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        n;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [5:0]  tag;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];

  // Reference model straight from the opcode definitions.
  function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    longint unsigned p;
    sh = int'(b % 32);
    case (c)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << sh;
      4'd6:  return a >> sh;
      4'd7:  return $unsigned($signed(a) >>> sh);
      4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: begin
        p = longint'(a) * longint'(b);
        return p[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic [5:0] t);
    in_valid = 1'b1; in_ctrl = c; in_a = a; in_b = b; in_tag = t;
    #1;
    chk("accept_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int seen;
    bit acc_now, con_now;
    exp_t e;

    vecs[0]  = '{OP_ADD,  32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0};
    vecs[1]  = '{OP_SUB,  32'h0,         32'h1,         32'hFFFF_FFFF, 1'b0, 1'b1};
    vecs[2]  = '{OP_AND,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 1'b0};
    vecs[3]  = '{OP_OR,   32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, 1'b1};
    vecs[4]  = '{OP_XOR,  32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 1'b0, 1'b0};
    vecs[5]  = '{OP_SLL,  32'h0000_0001, 32'h0000_0024, 32'h0000_0010, 1'b0, 1'b0};
    vecs[6]  = '{OP_SRL,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 1'b0};
    vecs[7]  = '{OP_SRA,  32'h8000_0000, 32'h0000_0021, 32'hC000_0000, 1'b0, 1'b1};
    vecs[8]  = '{OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0};
    vecs[9]  = '{OP_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0};
    vecs[10] = '{OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
    vecs[11] = '{4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_a = '0; in_b = '0; in_tag = '0;
    flush = 1'b0; out_ready = 1'b1;
    repeat (2) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_zero", out_zero, 0);
    chk("rst_neg", out_negative, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", in_ready, 1);

    // Wrapping add with tag 5
    issue(OP_ADD, 32'hFFFF_FFFF, 32'h1, 6'd5);
    chk("add_valid", out_valid, 1);
    chk("add_result", out_result, 0);
    chk("add_zero", out_zero, 1);
    chk("add_tag", out_tag, 5);

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].ctrl, vecs[i].a, vecs[i].b, 6'(i + 20));
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_result", i), out_result, vecs[i].res);
      chk($sformatf("vec%0d_zero", i), out_zero, vecs[i].z);
      chk($sformatf("vec%0d_neg", i), out_negative, vecs[i].n);
      chk($sformatf("vec%0d_tag", i), out_tag, 6'(i + 20));
    end
    tick();

    // Multiply latency; a pending add must not slip in while busy
    issue(OP_MUL, 32'h0001_0000, 32'h0001_0001, 6'd9);
    in_valid = 1'b1; in_ctrl = OP_ADD; in_a = 32'd1; in_b = 32'd1; in_tag = 6'd33;
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("mul_busy_%0d", i), busy, 1);
      chk($sformatf("mul_ready_%0d", i), in_ready, 0);
      chk($sformatf("mul_novalid_%0d", i), out_valid, 0);
      tick();
    end
    in_valid = 1'b0;
    chk("mul_valid", out_valid, 1);
    chk("mul_busy_done", busy, 0);
    chk("mul_result", out_result, 32'h0001_0000);
    chk("mul_tag", out_tag, 9);
    tick();
    chk("mul_consumed", out_valid, 0);

    // Backpressure: add held for 3 cycles while sub waits
    out_ready = 1'b0;
    issue(OP_ADD, 32'd5, 32'd7, 6'd11);
    in_valid = 1'b1; in_ctrl = OP_SUB; in_a = 32'd20; in_b = 32'd3; in_tag = 6'd12;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_ready_%0d", i), in_ready, 0);
      chk($sformatf("bp_valid_%0d", i), out_valid, 1);
      chk($sformatf("bp_result_%0d", i), out_result, 12);
      chk($sformatf("bp_tag_%0d", i), out_tag, 11);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_ready_release", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_second_valid", out_valid, 1);
    chk("bp_second_result", out_result, 17);
    chk("bp_second_tag", out_tag, 12);
    tick();
    chk("bp_no_dup", out_valid, 0);

    // Flush drops a held result
    out_ready = 1'b0;
    issue(OP_OR, 32'd1, 32'd2, 6'd13);
    flush = 1'b1;
    #1;
    chk("flush_ready_low", in_ready, 0);
    tick();
    flush = 1'b0;
    chk("flush_held_cleared", out_valid, 0);
    out_ready = 1'b1;

    // Flush at multiply cycle 10
    issue(OP_MUL, 32'd3, 32'd4, 6'd20);
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_valid", out_valid, 0);
    issue(OP_ADD, 32'd1, 32'd2, 6'd21);
    chk("after_flush_result", out_result, 3);
    chk("after_flush_tag", out_tag, 21);
    seen = 0;
    repeat (40) begin
      tick();
      if (out_valid) seen++;
    end
    chk("flush_no_ghost", seen, 0);

    // Reset mid-multiply
    issue(OP_MUL, 32'd7, 32'd9, 6'd22);
    repeat (5) tick();
    rst = 1'b1;
    #1;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_result", out_result, 0);
    chk("mrst_tag", out_tag, 0);
    chk("mrst_ready", in_ready, 0);
    tick();
    tick();
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      tick();
      if (out_valid || busy) seen++;
    end
    chk("mrst_no_ghost", seen, 0);

    // Random traffic against the scoreboard
    for (int cyc = 0; cyc < 2000; cyc++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_ctrl   = 4'($urandom_range(0, 15));
      in_a      = pick();
      in_b      = pick();
      in_tag    = 6'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc_now = in_valid && in_ready;
      con_now = out_valid && out_ready;
      if (con_now) begin
        if (sb.size() == 0) begin
          chk("rnd_unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("rnd_result", out_result, e.res);
          chk("rnd_tag", out_tag, e.tag);
          chk("rnd_zero", out_zero, (e.res == 0));
          chk("rnd_neg", out_negative, e.res[31]);
        end
      end
      if (acc_now) sb.push_back('{model(in_ctrl, in_a, in_b), in_tag});
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 80 && sb.size() != 0; i++) begin
      #1;
      if (out_valid) begin
        e = sb.pop_front();
        chk("drain_result", out_result, e.res);
        chk("drain_tag", out_tag, e.tag);
      end
      tick();
    end
    chk("drain_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
